// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//   mul_state_e : controller state encoding (IDLE/BUSY/DONE)
//   MUL_WIDTH   : default operand width, shared with the ALU and the
//                 writeback mux instances of the 12-bit processor
package mul_pkg;

  localparam int MUL_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath for mul_unit.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : capture a_i/b_i, clear accumulator and counter
//   step_i      : perform one shift-add iteration
//   a_i, b_i    : multiplicand / multiplier
//   last_o      : the current iteration is the final (WIDTH-th) one
//   prod_lo_o   : low half of the last completed product
//   prod_hi_o   : high half of the last completed product
module mul_datapath #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] prod_hi_o
);

  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    // The counter doubles as the shift amount: iteration k weighs bit k.
    addend    = mplier_q[0] ? (mcand_ext << cnt_q) : '0;
    acc_sum   = acc_q + addend;

    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;

    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_sum;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      // Publish the finished sum directly so the product is visible in DONE.
      if (last_o) begin
        prod_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod_lo_o = prod_q[WIDTH-1:0];
  assign prod_hi_o = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mul_unit.sv
// Iterative unsigned shift-add multiplier for the execute stage.
//   clk, reset  : clock, synchronous active-high reset
//   start_i     : request a multiply (accepted in IDLE or DONE only)
//   a_i, b_i    : operands, captured on the accepting edge
//   busy_o      : high for the WIDTH iteration cycles (pipeline stall)
//   done_o      : one-cycle pulse, product valid
//   prod_lo_o   : low half of the product
//   prod_hi_o   : high half of the product
// Handshake: start_i is a request sampled on a rising edge; it is honoured
// only when the unit is IDLE or DONE and ignored while busy_o is high.
// The controller state is held in state_q for checker binding.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] prod_hi_o
);

  mul_state_e state_q, state_d;
  logic       load;
  logic       step;
  logic       last;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);

  mul_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .step_i    (step),
    .a_i       (a_i),
    .b_i       (b_i),
    .last_o    (last),
    .prod_lo_o (prod_lo_o),
    .prod_hi_o (prod_hi_o)
  );

endmodule
